// File: rtl/reg_file_sb.sv
// Register file with a pending-write scoreboard and a self-clearing start-up sequence.
// After reset every register and pending bit is zeroed, one per cycle, before accesses are accepted.
module reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [AW-1:0]   RS1,
  input  logic [AW-1:0]   RS2,
  input  logic [AW-1:0]   RD,
  input  logic [XLEN-1:0] DIN,
  input  logic            WR,
  input  logic            RSV,
  input  logic [AW-1:0]   RSV_RD,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic            PEND1,
  output logic            PEND2,
  output logic            BUSY
);

  localparam int NREG = 2**AW;

  // state | meaning
  // CLEAR | zeroing register/pending entry cnt, accesses ignored
  // READY | normal read/write/reserve operation
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   cnt;
  logic [AW-1:0]   cnt_nxt;

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend;

  logic            clr_en;
  logic            wr_en;
  logic            rsv_en;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == '1) state_nxt = READY;
      end
      READY: begin
        state_nxt = READY;
      end
    endcase
  end

  assign BUSY   = (state == CLEAR);
  assign clr_en = BUSY && !RST;
  assign wr_en  = !BUSY && !RST && WR && (RD != '0);
  assign rsv_en = !BUSY && !RST && RSV && (RSV_RD != '0);

  // Contents are deliberately not reset; the clear sequence zeroes them.
  always_ff @(posedge CLK) begin
    if (clr_en) begin
      regs[cnt] <= '0;
    end else if (wr_en) begin
      regs[RD] <= DIN;
    end
  end

  // The reserve is applied after the write so it wins on a same-register collision.
  always_ff @(posedge CLK) begin
    if (clr_en) begin
      pend[cnt] <= 1'b0;
    end else begin
      if (wr_en)  pend[RD]     <= 1'b0;
      if (rsv_en) pend[RSV_RD] <= 1'b1;
    end
  end

  function automatic logic [XLEN:0] read_port(input logic [AW-1:0] rs);
    logic [XLEN:0] res;
    res = '0;
    if (BUSY || rs == '0) begin
      res = '0;
    end else if (BYPASS != 0 && WR && RD == rs) begin
      res = {1'b0, DIN};
    end else begin
      res = {pend[rs], regs[rs]};
    end
    return res;
  endfunction

  always_comb begin
    {PEND1, RD1} = read_port(RS1);
    {PEND2, RD2} = read_port(RS2);
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: forwarding and non-forwarding instances driven in parallel,
// checked every cycle against an array-based model plus directed literal expectations.
module tb_reg_file_sb;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  RS1, RS2, RD, RSV_RD;
  logic [31:0] DIN;
  logic        WR, RSV;

  logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;
  logic        b_p1, b_p2, n_p1, n_p2, b_busy, n_busy;

  int checks = 0;
  int errors = 0;

  reg_file_sb #(.XLEN(32), .AW(5), .BYPASS(1)) dut (
    .CLK(CLK), .RST(RST), .RS1(RS1), .RS2(RS2), .RD(RD), .DIN(DIN), .WR(WR),
    .RSV(RSV), .RSV_RD(RSV_RD), .RD1(b_rd1), .RD2(b_rd2), .PEND1(b_p1),
    .PEND2(b_p2), .BUSY(b_busy)
  );

  reg_file_sb #(.XLEN(32), .AW(5), .BYPASS(0)) dut_nb (
    .CLK(CLK), .RST(RST), .RS1(RS1), .RS2(RS2), .RD(RD), .DIN(DIN), .WR(WR),
    .RSV(RSV), .RSV_RD(RSV_RD), .RD1(n_rd1), .RD2(n_rd2), .PEND1(n_p1),
    .PEND2(n_p2), .BUSY(n_busy)
  );

  always #5 CLK = ~CLK;

  // Behavioural model state
  logic [31:0] m_file [32];
  bit          m_pend [32];
  bit          m_busy  = 1'b0;
  bit          m_valid = 1'b0;
  int          m_idx   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] rs, input bit bp);
    if (m_busy || rs == 0) return 32'h0;
    if (bp && WR && RD == rs) return DIN;
    return m_file[rs];
  endfunction

  function automatic logic [31:0] exp_pend(input logic [4:0] rs, input bit bp);
    if (m_busy || rs == 0) return 32'h0;
    if (bp && WR && RD == rs) return 32'h0;
    return {31'h0, m_pend[rs]};
  endfunction

  // Model update on each rising edge from the inputs presented before it
  initial begin
    forever begin
      @(posedge CLK);
      if (RST) begin
        m_valid = 1'b1;
        m_busy  = 1'b1;
        m_idx   = 0;
      end else if (m_valid && m_busy) begin
        m_file[m_idx] = 32'h0;
        m_pend[m_idx] = 1'b0;
        m_idx++;
        if (m_idx == 32) m_busy = 1'b0;
      end else if (m_valid) begin
        if (WR && RD != 0) begin
          m_file[RD] = DIN;
          m_pend[RD] = 1'b0;
        end
        if (RSV && RSV_RD != 0) m_pend[RSV_RD] = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge CLK);
      if (m_valid) begin
        chk("busy_b", {31'h0, b_busy}, {31'h0, m_busy});
        chk("busy_n", {31'h0, n_busy}, {31'h0, m_busy});
        chk("rd1_b", b_rd1, exp_rd(RS1, 1'b1));
        chk("rd2_b", b_rd2, exp_rd(RS2, 1'b1));
        chk("pend1_b", {31'h0, b_p1}, exp_pend(RS1, 1'b1));
        chk("pend2_b", {31'h0, b_p2}, exp_pend(RS2, 1'b1));
        chk("rd1_n", n_rd1, exp_rd(RS1, 1'b0));
        chk("rd2_n", n_rd2, exp_rd(RS2, 1'b0));
        chk("pend1_n", {31'h0, n_p1}, exp_pend(RS1, 1'b0));
        chk("pend2_n", {31'h0, n_p2}, exp_pend(RS2, 1'b0));
      end
    end
  end

  task automatic drive_idle();
    WR = 0; RSV = 0; RD = 0; RSV_RD = 0; DIN = 0; RS1 = 0; RS2 = 0;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic count_busy(input string name);
    int  n;
    bit  done;
    n    = 0;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge CLK);
      if (b_busy) n++;
      else done = 1;
    end
    chk(name, n, 32);
  endtask

  task automatic sweep_zero(input string name);
    WR = 0; RSV = 0;
    for (int i = 0; i < 32; i++) begin
      next_cycle();
      RS1 = 5'(i);
      RS2 = 5'(31 - i);
      @(negedge CLK);
      chk(name, b_rd1 | b_rd2 | n_rd1 | n_rd2, 32'h0);
    end
  endtask

  initial begin
    drive_idle();
    RST = 1;
    next_cycle();
    RST = 0;
    // Clear with writes and reserves hammering throughout
    WR = 1; RSV = 1; RD = 3; RSV_RD = 4; DIN = 32'hA5A5_0001; RS1 = 3; RS2 = 4;
    count_busy("clear_len");
    drive_idle();
    sweep_zero("clear_zero");

    // Write then read, forwarding vs not
    next_cycle();
    WR = 1; RD = 5; DIN = 32'hDEAD_BEEF; RS1 = 5;
    @(negedge CLK);
    chk("fwd_same", b_rd1, 32'hDEAD_BEEF);
    chk("nofwd_same", n_rd1, 32'h0);
    next_cycle();
    WR = 0;
    @(negedge CLK);
    chk("fwd_next", b_rd1, 32'hDEAD_BEEF);
    chk("nofwd_next", n_rd1, 32'hDEAD_BEEF);

    // Register zero
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      WR = 1; RD = 0; DIN = 32'hFFFF_FFFF; RSV = 1; RSV_RD = 0; RS1 = 0;
      @(negedge CLK);
      chk("r0_rd1", b_rd1 | n_rd1, 32'h0);
      chk("r0_pend1", {31'h0, b_p1 | n_p1}, 32'h0);
    end
    drive_idle();

    // Scoreboard reserve then write
    next_cycle();
    RSV = 1; RSV_RD = 7;
    next_cycle();
    RSV = 0; RS2 = 7;
    @(negedge CLK);
    chk("sb_pend", {31'h0, b_p2}, 32'h1);
    next_cycle();
    WR = 1; RD = 7; DIN = 32'h12;
    @(negedge CLK);
    chk("sb_fwd_pend", {31'h0, b_p2}, 32'h0);
    chk("sb_fwd_rd", b_rd2, 32'h12);
    chk("sb_nofwd_pend", {31'h0, n_p2}, 32'h1);
    next_cycle();
    WR = 0;
    @(negedge CLK);
    chk("sb_after_pend", {31'h0, n_p2}, 32'h0);

    // Simultaneous write and reserve
    next_cycle();
    WR = 1; RSV = 1; RD = 9; RSV_RD = 9; DIN = 32'h0BAD_F00D;
    next_cycle();
    WR = 0; RSV = 0; RS1 = 9;
    @(negedge CLK);
    chk("wr_rsv_rd", b_rd1, 32'h0BAD_F00D);
    chk("wr_rsv_pend", {31'h0, b_p1}, 32'h1);
    chk("wr_rsv_rd_n", n_rd1, 32'h0BAD_F00D);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 2000; c++) begin
      next_cycle();
      RST    = ($urandom_range(0, 399) == 0);
      WR     = $urandom_range(0, 1) == 1;
      RD     = 5'($urandom_range(0, 31));
      DIN    = $urandom;
      RSV    = ($urandom_range(0, 3) == 0);
      RSV_RD = 5'($urandom_range(0, 31));
      RS1    = ($urandom_range(0, 1) == 1) ? RD : 5'($urandom_range(0, 31));
      RS2    = ($urandom_range(0, 2) == 0) ? RSV_RD : 5'($urandom_range(0, 31));
    end
    next_cycle();
    RST = 0;
    drive_idle();
    for (int i = 0; i < 40 && b_busy; i++) next_cycle();

    // Reset restarted in the middle of clear
    RST = 1;
    next_cycle();
    RST = 0;
    repeat (10) @(posedge CLK);
    #1;
    RST = 1;
    @(negedge CLK);
    chk("mid_busy", {31'h0, b_busy}, 32'h1);
    next_cycle();
    RST = 0;
    count_busy("mid_clear_len");
    sweep_zero("mid_clear_zero");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
